// File: rtl/digit_scan_ctrl.sv
// Scan controller for a 4-digit 7-segment display: rotates a one-hot nibble-mux
// select, drives active-low anodes with a blanking gap, and commits display words on frame wrap.
module digit_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  digit_en,
    input  logic [15:0] data_in,
    input  logic        load,
    output logic [15:0] disp_word,
    output logic [3:0]  select,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int unsigned MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [1:0]         idx, idx_n;
    logic [15:0]        pend_word, pend_word_n;
    logic               pend_flag, pend_flag_n;
    logic [15:0]        disp_word_n;
    logic [3:0]         select_n;
    logic [3:0]         an_n;
    logic               wrap;
    logic               stop;
    logic               commit;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= 2'd0;
            pend_word  <= 16'h0000;
            pend_flag  <= 1'b0;
            disp_word  <= 16'h0000;
            select     <= 4'b0001;
            an         <= 4'b1111;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            pend_word  <= pend_word_n;
            pend_flag  <= pend_flag_n;
            disp_word  <= disp_word_n;
            select     <= select_n;
            an         <= an_n;
            frame_done <= wrap;
        end
    end

    // Next-state, slot timing and next registered outputs
    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CNT_W'(1);
        idx_n       = idx;
        wrap        = 1'b0;
        stop        = 1'b0;
        pend_word_n = pend_word;
        pend_flag_n = pend_flag;
        disp_word_n = disp_word;

        case (state)
            IDLE: begin
                cnt_n = cnt;
                if (enable) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    idx_n   = 2'd0;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    stop    = 1'b1;
                end else if (cnt == BLANK_LAST) begin
                    state_n = SHOW;
                    cnt_n   = '0;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    stop    = 1'b1;
                end else if (cnt == SHOW_LAST) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    idx_n   = idx + 2'd1;
                    wrap    = (idx == 2'd3);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // A load coinciding with a commit edge bypasses the pending register
        commit = wrap || stop || (state == IDLE);
        if (load) begin
            pend_word_n = data_in;
            pend_flag_n = 1'b1;
        end
        if (commit) begin
            if (load) begin
                disp_word_n = data_in;
            end else if (pend_flag) begin
                disp_word_n = pend_word;
            end
            pend_flag_n = 1'b0;
        end

        // Select derived from the index by shift so it can only ever be one-hot
        select_n = 4'b0001 << idx_n;
        an_n     = (state_n == SHOW && digit_en[idx_n]) ? ~select_n : 4'b1111;
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl: expected outputs are queued as stimulus is
// driven and popped for comparison one clock later.
module tb_digit_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  digit_en;
    logic [15:0] data_in;
    logic        load;
    logic [15:0] disp_word;
    logic [3:0]  select;
    logic [3:0]  an;
    logic        frame_done;

    typedef struct packed {
        logic [3:0]  an;
        logic [3:0]  sel;
        logic        fd;
        logic [15:0] dw;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    digit_scan_ctrl #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digit_en   (digit_en),
        .data_in    (data_in),
        .load       (load),
        .disp_word  (disp_word),
        .select     (select),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Queue the expected outputs, advance one clock, then pop and compare
    task automatic tick(input string tag, input logic [3:0] e_an, input logic [3:0] e_sel,
                        input logic e_fd, input logic [15:0] e_dw);
        exp_t e;
        exp_q.push_back('{an: e_an, sel: e_sel, fd: e_fd, dw: e_dw});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        assert (an === e.an) else begin
            errors++;
            $error("FAIL %s an: got %b expected %b", tag, an, e.an);
        end
        checks++;
        assert (select === e.sel) else begin
            errors++;
            $error("FAIL %s select: got %b expected %b", tag, select, e.sel);
        end
        checks++;
        assert (frame_done === e.fd) else begin
            errors++;
            $error("FAIL %s frame_done: got %b expected %b", tag, frame_done, e.fd);
        end
        checks++;
        assert (disp_word === e.dw) else begin
            errors++;
            $error("FAIL %s disp_word: got %h expected %h", tag, disp_word, e.dw);
        end
    endtask

    // One scan frame (or its first ncyc cycles): 2 blank + 4 lit cycles per digit
    task automatic frame(input string tag, input logic [3:0] mask, input logic fd_first,
                         input logic [15:0] dw, input int ncyc, input int load_idx,
                         input logic [15:0] load_val);
        int         d;
        int         p;
        logic [3:0] s;
        logic [3:0] a;
        for (int i = 0; i < ncyc; i++) begin
            d       = i / 6;
            p       = i % 6;
            load    = (i == load_idx);
            data_in = load_val;
            s       = 4'b0001 << d;
            a       = (p < 2 || !mask[d]) ? 4'b1111 : ~s;
            tick(tag, a, s, fd_first && (i == 0), dw);
        end
        load = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        digit_en = 4'b1111;
        data_in  = 16'h0000;
        load     = 1'b0;

        tick("reset", 4'b1111, 4'b0001, 1'b0, 16'h0000);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick("idle", 4'b1111, 4'b0001, 1'b0, 16'h0000);

        enable = 1'b1;
        frame("scan_first", 4'b1111, 1'b0, 16'h0000, 24, -1, 16'h0000);
        frame("scan_repeat", 4'b1111, 1'b1, 16'h0000, 24, -1, 16'h0000);

        digit_en = 4'b0101;
        frame("mask_0101", 4'b0101, 1'b1, 16'h0000, 24, -1, 16'h0000);
        digit_en = 4'b1111;

        frame("load_mid", 4'b1111, 1'b1, 16'h0000, 24, 8, 16'h1234);
        frame("commit_wrap", 4'b1111, 1'b1, 16'h1234, 24, -1, 16'h0000);

        frame("pre_drop", 4'b1111, 1'b1, 16'h1234, 16, 3, 16'h4321);
        enable = 1'b0;
        tick("drop_enable", 4'b1111, 4'b0100, 1'b0, 16'h4321);
        tick("idle_hold", 4'b1111, 4'b0100, 1'b0, 16'h4321);

        load    = 1'b1;
        data_in = 16'hBEEF;
        tick("idle_load", 4'b1111, 4'b0100, 1'b0, 16'hBEEF);
        load    = 1'b0;
        data_in = 16'h0000;
        tick("idle_after_load", 4'b1111, 4'b0100, 1'b0, 16'hBEEF);

        enable = 1'b1;
        frame("restart", 4'b1111, 1'b0, 16'hBEEF, 24, -1, 16'h0000);

        frame("pre_reset", 4'b1111, 1'b1, 16'hBEEF, 21, 3, 16'h5555);
        reset = 1'b1;
        tick("mid_reset", 4'b1111, 4'b0001, 1'b0, 16'h0000);
        reset  = 1'b0;
        enable = 1'b0;
        tick("post_reset_idle", 4'b1111, 4'b0001, 1'b0, 16'h0000);
        enable = 1'b1;
        frame("post_reset_scan", 4'b1111, 1'b0, 16'h0000, 24, -1, 16'h0000);
        frame("pending_dropped", 4'b1111, 1'b1, 16'h0000, 24, -1, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
